avalon_mm_fifo_bridge: RTL and testbench



---
 rtl/avalon_mm_fifo_bridge_pkg.sv | 31 +++
 rtl/bridge_sync_fifo.sv | 65 ++++++
 rtl/avalon_mm_fifo_bridge.sv | 159 +++++++++++++++
 tb/tb_avalon_mm_fifo_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mm_fifo_bridge_pkg.sv
// avalon_bridge_pkg: shared types, width helpers and derived widths for the
// Avalon-MM FIFO bridge. The derived localparams and cmd_entry_t describe the
// default 32-bit data / 10-bit address / 16-deep configuration; the bridge
// re-derives the same quantities from its own parameters with clog2().
package avalon_bridge_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_RSP_DEPTH = 16;

    localparam int BE_W        = DEF_DATA_W / 8;
    localparam int BYTE_ADDR_W = DEF_ADDR_W + clog2(BE_W);
    localparam int CNT_W       = clog2(DEF_RSP_DEPTH + 1);

    // One queued command, in FIFO storage order.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] writedata;
        logic [DEF_ADDR_W-1:0] address;
        logic                  read;
        logic                  write;
        logic [BE_W-1:0]       byteenable;
    } cmd_entry_t;

endpackage

// File: rtl/bridge_sync_fifo.sv
// bridge_sync_fifo: single-clock show-ahead FIFO. The head entry is always on
// dout; a push into an empty FIFO shows up one cycle later (no fall-through).
// full/empty/count are registered. Storage is reset so dout is 0 out of reset.
module bridge_sync_fifo
    import avalon_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW    = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt_nxt;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_nxt = count;
        if (do_push && !do_pop)      cnt_nxt = count + 1'b1;
        else if (!do_push && do_pop) cnt_nxt = count - 1'b1;
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= cnt_nxt;
            full  <= (cnt_nxt == CW'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/avalon_mm_fifo_bridge.sv
// avalon_mm_fifo_bridge: Avalon-MM pipeline bridge with a command FIFO and a
// read-response FIFO. Reads are credit limited so the response FIFO cannot
// overflow under legal traffic. Define AVALON_BRIDGE_EOP_EN to carry
// endofpacket from the master side to the slave side with each response.
module avalon_mm_fifo_bridge
    import avalon_bridge_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int CMD_DEPTH = 16,
    parameter int RSP_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [ADDR_W-1:0]                 slave_address,
    input  logic [DATA_W/8-1:0]               slave_byteenable,
    input  logic                              slave_read,
    input  logic                              slave_write,
    input  logic [DATA_W-1:0]                 slave_writedata,
    output logic                              slave_waitrequest,
    output logic [DATA_W-1:0]                 slave_readdata,
    output logic                              slave_readdatavalid,
`ifdef AVALON_BRIDGE_EOP_EN
    output logic                              slave_endofpacket,
    input  logic                              master_endofpacket,
`endif
    output logic [ADDR_W+clog2(DATA_W/8)-1:0] master_address,
    output logic [DATA_W/8-1:0]               master_byteenable,
    output logic [DATA_W-1:0]                 master_writedata,
    output logic                              master_read,
    output logic                              master_write,
    input  logic                              master_waitrequest,
    input  logic [DATA_W-1:0]                 master_readdata,
    input  logic                              master_readdatavalid,
    output logic                              rsp_error
);
    localparam int BE      = DATA_W / 8;
    localparam int OFS     = clog2(BE);
    localparam int MADDR_W = ADDR_W + OFS;
    localparam int OCNT_W  = clog2(RSP_DEPTH + 1);
`ifdef AVALON_BRIDGE_EOP_EN
    localparam int RSP_W   = DATA_W + 1;
`else
    localparam int RSP_W   = DATA_W;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] writedata;
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [BE-1:0]     byteenable;
    } cmd_t;

    cmd_t                      cmd_in, cmd_head;
    logic                      cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [clog2(CMD_DEPTH+1)-1:0] cmd_count;
    logic [RSP_W-1:0]          rsp_din, rsp_dout;
    logic                      rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [clog2(RSP_DEPTH+1)-1:0] rsp_count;
    logic [OCNT_W-1:0]         outstanding;
    logic                      rd_issue;
    logic                      unused_cnt;

    // ---------------- command path ----------------
    assign cmd_in = '{writedata:  slave_writedata,
                      address:    slave_address,
                      read:       slave_read,
                      write:      slave_write,
                      byteenable: slave_byteenable};

    assign slave_waitrequest = cmd_full;
    assign cmd_push = (slave_read | slave_write) & ~cmd_full;

    bridge_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_push),
        .din     (cmd_in),
        .pop     (cmd_pop),
        .dout    (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty),
        .count   (cmd_count)
    );

    assign master_address    = MADDR_W'(cmd_head.address) << OFS;
    assign master_byteenable = cmd_head.byteenable;
    assign master_writedata  = cmd_head.writedata;
    assign master_write      = ~cmd_empty & cmd_head.write;
    assign master_read       = ~cmd_empty & cmd_head.read &
                               (outstanding < OCNT_W'(RSP_DEPTH));
    assign cmd_pop  = (master_read | master_write) & ~master_waitrequest;
    assign rd_issue = master_read & ~master_waitrequest;

    // Read credits: taken on issue, returned when a response leaves the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (rd_issue && !rsp_pop) begin
            if (outstanding != OCNT_W'(RSP_DEPTH)) outstanding <= outstanding + 1'b1;
        end else if (!rd_issue && rsp_pop) begin
            if (outstanding != '0) outstanding <= outstanding - 1'b1;
        end
    end

    // ---------------- response path ----------------
`ifdef AVALON_BRIDGE_EOP_EN
    assign rsp_din = {master_readdata, master_endofpacket};
`else
    assign rsp_din = master_readdata;
`endif
    assign rsp_push = master_readdatavalid & ~rsp_full;
    assign rsp_pop  = ~rsp_empty;

    bridge_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rsp_push),
        .din     (rsp_din),
        .pop     (rsp_pop),
        .dout    (rsp_dout),
        .full    (rsp_full),
        .empty   (rsp_empty),
        .count   (rsp_count)
    );

    // Occupancy counts are not needed by the bridge itself.
    assign unused_cnt = ^{cmd_count, rsp_count};

    // Slave-side response registers; one entry drained per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_readdatavalid <= 1'b0;
            slave_readdata      <= '0;
`ifdef AVALON_BRIDGE_EOP_EN
            slave_endofpacket   <= 1'b0;
`endif
        end else begin
            slave_readdatavalid <= rsp_pop;
`ifdef AVALON_BRIDGE_EOP_EN
            slave_endofpacket   <= rsp_pop & rsp_dout[0];
            if (rsp_pop) slave_readdata <= rsp_dout[RSP_W-1:1];
`else
            if (rsp_pop) slave_readdata <= rsp_dout;
`endif
        end
    end

    // Sticky error on a response with no read outstanding or no room left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_error <= 1'b0;
        end else if (master_readdatavalid && (outstanding == '0 || rsp_full)) begin
            rsp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_mm_fifo_bridge.sv
// Directed bench for avalon_mm_fifo_bridge (default parameters), with a small
// downstream memory model and scoreboard for the mixed-traffic phase.
module tb_avalon_mm_fifo_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  slave_address;
    logic [3:0]  slave_byteenable;
    logic        slave_read, slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic [11:0] master_address;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic        master_read, master_write;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        rsp_error;
`ifdef AVALON_BRIDGE_EOP_EN
    logic        slave_endofpacket;
    logic        master_endofpacket;
`endif

    // directed vs. model-driven downstream signals
    logic        auto_en = 1'b0;
    logic        dir_wr = 1'b0, dir_rdv = 1'b0, dir_eop = 1'b0;
    logic [31:0] dir_rdata = '0;
    logic        m_wr = 1'b0, m_rdv = 1'b0;
    logic [31:0] m_rdata = '0;

    assign master_waitrequest   = auto_en ? m_wr    : dir_wr;
    assign master_readdatavalid = auto_en ? m_rdv   : dir_rdv;
    assign master_readdata      = auto_en ? m_rdata : dir_rdata;
`ifdef AVALON_BRIDGE_EOP_EN
    assign master_endofpacket   = auto_en ? 1'b0    : dir_eop;
`endif

    avalon_mm_fifo_bridge dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .slave_address        (slave_address),
        .slave_byteenable     (slave_byteenable),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_waitrequest    (slave_waitrequest),
        .slave_readdata       (slave_readdata),
        .slave_readdatavalid  (slave_readdatavalid),
`ifdef AVALON_BRIDGE_EOP_EN
        .slave_endofpacket    (slave_endofpacket),
        .master_endofpacket   (master_endofpacket),
`endif
        .master_address       (master_address),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .rsp_error            (rsp_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // master-side transfer monitor (directed phases)
    logic [43:0] wq[$];
    int          rd_cnt = 0;
    always @(negedge clk) begin
        if (!auto_en && master_write && !master_waitrequest)
            wq.push_back({master_address, master_writedata});
        if (!auto_en && master_read && !master_waitrequest)
            rd_cnt++;
    end

    // downstream memory model: in-order responses with random latency/stall
    logic [31:0] dmem [1024];
    logic [31:0] pq[$];
    int          pdue[$];
    int          cyc = 0;
    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        forever begin
            @(negedge clk);
            if (auto_en && master_write && !master_waitrequest)
                dmem[master_address[11:2]] = master_writedata;
            if (auto_en && master_read && !master_waitrequest) begin
                pq.push_back(dmem[master_address[11:2]]);
                pdue.push_back(cyc + int'($urandom_range(1, 4)));
            end
            @(posedge clk); #1;
            cyc++;
            m_wr  = auto_en && ($urandom % 4 == 0);
            m_rdv = 1'b0;
            if (auto_en && pq.size() > 0 && pdue[0] <= cyc) begin
                m_rdata = pq.pop_front();
                void'(pdue.pop_front());
                m_rdv   = 1'b1;
            end
        end
    end

    // scoreboard (mixed-traffic phase)
    logic        sb_en = 1'b0;
    logic [31:0] expq[$];
    logic [31:0] exp_mem [16];
    int          nrsp = 0;
    always @(negedge clk) begin
        if (sb_en && slave_readdatavalid) begin
            nrsp++;
            if (expq.size() == 0) chk("sb_extra_rsp", 1, 0);
            else                  chk("sb_rdata", slave_readdata, expq.pop_front());
        end
    end

    initial begin
        int idx;
        int nrd;
        logic acc;
        logic [3:0]  a;
        logic [31:0] d;
        logic        rd;

        reset_n = 1'b0;
        slave_address = '0; slave_byteenable = '0;
        slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitreq", slave_waitrequest, 0);
        chk("rst_mread",   master_read, 0);
        chk("rst_mwrite",  master_write, 0);
        chk("rst_maddr",   master_address, 0);
        chk("rst_rdv",     slave_readdatavalid, 0);
        chk("rst_err",     rsp_error, 0);
        reset_n = 1'b1;

        // --- single write, downstream stalled so the head can be observed
        @(posedge clk); #1;
        dir_wr = 1'b1;
        slave_write = 1'b1; slave_address = 10'h005;
        slave_byteenable = 4'hF; slave_writedata = 32'hDEADBEEF;
        @(negedge clk);
        chk("w1_not_yet", master_write, 0);
        @(posedge clk); #1;
        slave_write = 1'b0;
        @(negedge clk);
        chk("w1_mwrite", master_write, 1);
        chk("w1_maddr",  master_address, 12'h014);
        chk("w1_mdata",  master_writedata, 32'hDEADBEEF);
        chk("w1_mbe",    master_byteenable, 4'hF);
        @(posedge clk); #1;
        dir_wr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("w1_popped", master_write, 0);
        chk("w1_count",  wq.size(), 1);
        wq.delete();

        // --- 20 back-to-back writes into a stalled downstream
        @(posedge clk); #1;
        dir_wr = 1'b1;
        idx = 0;
        slave_write = 1'b1; slave_address = 10'd0; slave_writedata = 32'h100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!slave_waitrequest) idx++;
            @(posedge clk); #1;
            slave_address = 10'(idx); slave_writedata = 32'h100 + idx;
        end
        chk("wf_accepted", idx, 16);
        dir_wr = 1'b0;
        @(negedge clk);
        chk("wf_full_hold", slave_waitrequest, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wf_full_release", slave_waitrequest, 0);
        for (int c = 0; c < 100 && idx < 20; c++) begin
            if (!slave_waitrequest) idx++;
            @(posedge clk); #1;
            if (idx < 20) begin
                slave_address = 10'(idx); slave_writedata = 32'h100 + idx;
            end else begin
                slave_write = 1'b0;
            end
            @(negedge clk);
        end
        slave_write = 1'b0;
        repeat (30) @(negedge clk);
        chk("wf_count", wq.size(), 20);
        for (int i = 0; i < 20 && i < wq.size(); i++)
            chk($sformatf("wf_entry%0d", i), wq[i], {12'(i * 4), 32'h100 + 32'(i)});

        // --- 20 reads, downstream never answers: credits run out at 16
        @(posedge clk); #1;
        rd_cnt = 0; idx = 0;
        slave_read = 1'b1; slave_address = 10'd0;
        for (int c = 0; c < 100 && idx < 20; c++) begin
            @(negedge clk);
            if (!slave_waitrequest) idx++;
            @(posedge clk); #1;
            if (idx < 20) slave_address = 10'(idx);
            else          slave_read = 1'b0;
        end
        slave_read = 1'b0;
        chk("rd_all_accepted", idx, 20);
        repeat (5) @(negedge clk);
        chk("rd_credit_limit", rd_cnt, 16);
        chk("rd_blocked", master_read, 0);

        // one response: latency M -> M+2, frees one credit
        @(posedge clk); #1;
        dir_rdv = 1'b1; dir_rdata = 32'h12345678; dir_eop = 1'b1;
        @(negedge clk);
        chk("rsp_m0", slave_readdatavalid, 0);
        @(posedge clk); #1;
        dir_rdv = 1'b0; dir_eop = 1'b0;
        @(negedge clk);
        chk("rsp_m1", slave_readdatavalid, 0);
        @(negedge clk);
        chk("rsp_m2_valid", slave_readdatavalid, 1);
        chk("rsp_m2_data",  slave_readdata, 32'h12345678);
`ifdef AVALON_BRIDGE_EOP_EN
        chk("rsp_m2_eop",   slave_endofpacket, 1);
`endif
        repeat (3) @(negedge clk);
        chk("rd_one_more", rd_cnt, 17);
        chk("rd_blocked2", master_read, 0);
        chk("rd_no_err",   rsp_error, 0);

        // --- reset with reads outstanding
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_waitreq", slave_waitrequest, 0);
        chk("mrst_mread",   master_read, 0);
        chk("mrst_mwrite",  master_write, 0);
        chk("mrst_maddr",   master_address, 0);
        chk("mrst_rdata",   slave_readdata, 0);
        chk("mrst_rdv",     slave_readdatavalid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("stray_pre_err", rsp_error, 0);
        dir_rdv = 1'b1; dir_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        dir_rdv = 1'b0;
        @(negedge clk);
        chk("stray_err", rsp_error, 1);
        @(negedge clk);
        chk("stray_data", {slave_readdatavalid, slave_readdata}, {1'b1, 32'hA5A5A5A5});

        // --- mixed traffic against the memory model
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        auto_en = 1'b1; sb_en = 1'b1;
        nrd = 0;
        slave_byteenable = 4'hF;
        for (int n = 0; n < 200; n++) begin
            rd = 1'($urandom % 2);
            a  = 4'($urandom % 16);
            d  = $urandom;
            slave_read = rd; slave_write = ~rd;
            slave_address = 10'(a); slave_writedata = d;
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(negedge clk);
                acc = !slave_waitrequest;
                @(posedge clk); #1;
            end
            if (!acc) chk("mix_accept_timeout", 0, 1);
            if (rd) begin
                expq.push_back(exp_mem[a]);
                nrd++;
            end else begin
                exp_mem[a] = d;
            end
            slave_read = 1'b0; slave_write = 1'b0;
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
        end
        for (int c = 0; c < 2000 && nrsp < nrd; c++) @(negedge clk);
        chk("mix_rsp_count", nrsp, nrd);
        chk("mix_err", rsp_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
